// File: rtl/fetch_unit.sv
// fetch_unit: PC register, in-order instruction fetch with tag queue and output FIFO.
// Optional misaligned-redirect trap (HALT state, misalign_err) when FETCH_MISALIGN_CHECK_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;
`else
    typedef enum logic [0:0] {ST_RUN = 1'b0} state_t;
`endif
    state_t r_state, w_stateNext;

    logic [31:0]   r_pc;
    logic [31:0]   r_tagMem [FIFO_DEPTH];
    logic [PW-1:0] r_tagWr, r_tagRd;
    logic [CW-1:0] r_inflight;
    logic [31:0]   r_pcMem [FIFO_DEPTH];
    logic [31:0]   r_instrMem [FIFO_DEPTH];
    logic [PW-1:0] r_fifoWr, r_fifoRd;
    logic [CW-1:0] r_fifoCnt;
    logic [CW-1:0] r_dropCnt;

    logic [SW-1:0] w_credit;
    logic          w_reqFire;
    logic          w_dropping;
    logic          w_rspPush;
    logic          w_pop;
    logic          w_trap;
    logic [31:0]   w_targetPc;

    // Every outstanding or buffered word holds a slot, so the FIFO can never overflow.
    assign w_credit       = SW'(r_inflight) + SW'(r_dropCnt) + SW'(r_fifoCnt);
    assign imem_req_valid = (r_state == ST_RUN) && !redirect_valid && (w_credit < SW'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign w_dropping     = (r_dropCnt != '0);
    assign w_rspPush      = imem_rsp_valid && !w_dropping;
    assign w_pop          = instr_valid && instr_ready;
    assign w_targetPc     = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalignErr;
    assign w_trap       = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = r_misalignErr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misalignErr <= 1'b0;
        end else if (w_trap) begin
            r_misalignErr <= 1'b1;
        end
    end
`else
    logic w_unusedLowBits;
    assign w_trap          = 1'b0;
    assign w_unusedLowBits = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (w_trap) begin
            w_stateNext = ST_HALT;
        end
`endif
    end

    // A redirect flushes both queues; everything still in flight becomes a pending drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_tagWr    <= '0;
            r_tagRd    <= '0;
            r_inflight <= '0;
            r_fifoWr   <= '0;
            r_fifoRd   <= '0;
            r_fifoCnt  <= '0;
            r_dropCnt  <= '0;
        end else if (redirect_valid) begin
            r_tagWr    <= '0;
            r_tagRd    <= '0;
            r_inflight <= '0;
            r_fifoWr   <= '0;
            r_fifoRd   <= '0;
            r_fifoCnt  <= '0;
            r_dropCnt  <= r_dropCnt + r_inflight - CW'(imem_rsp_valid);
            if (!w_trap) begin
                r_pc <= w_targetPc;
            end
        end else begin
            if (w_reqFire) begin
                r_tagWr <= r_tagWr + PW'(1);
                r_pc    <= r_pc + 32'd4;
            end
            if (w_rspPush) begin
                r_tagRd  <= r_tagRd + PW'(1);
                r_fifoWr <= r_fifoWr + PW'(1);
            end
            if (w_pop) begin
                r_fifoRd <= r_fifoRd + PW'(1);
            end
            r_inflight <= r_inflight + CW'(w_reqFire) - CW'(w_rspPush);
            r_fifoCnt  <= r_fifoCnt + CW'(w_rspPush) - CW'(w_pop);
            if (imem_rsp_valid && w_dropping) begin
                r_dropCnt <= r_dropCnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_reqFire) begin
            r_tagMem[r_tagWr] <= r_pc;
        end
        if (w_rspPush && !redirect_valid) begin
            r_pcMem[r_fifoWr]    <= r_tagMem[r_tagRd];
            r_instrMem[r_fifoWr] <= imem_rsp_data;
        end
    end

    assign instr_valid = (r_fifoCnt != '0);
    assign Instr       = instr_valid ? r_instrMem[r_fifoRd] : 32'h0;
    assign PC          = instr_valid ? r_pcMem[r_fifoRd] : 32'h0;
    assign PCPlus4     = instr_valid ? (r_pcMem[r_fifoRd] + 32'd4) : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a sequential-PC
// reference model and a behavioural in-order instruction memory with variable latency.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Instr(Instr),
        .PC(PC),
        .PCPlus4(PCPlus4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    int          nChecks = 0;
    int          nPass = 0;
    int          cyc;
    int          reqCount;
    int          popCount;
    int          lastDue;
    int          memLatMin;
    int          memLatMax;
    logic        halted;
    logic [31:0] expIssuePc;
    logic [31:0] expOutPc;
    logic [31:0] memAddrQ [$];
    int          memDueQ [$];
    logic        lastReqValid;
    logic        lastInstrValid;
    logic        lastRspValid;
    logic [31:0] lastReqAddr;
    logic [31:0] lastPc;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    endtask

    // Leaves the bench at a negedge with reset released and the model at its start point.
    task automatic doReset();
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        memAddrQ.delete();
        memDueQ.delete();
        lastDue = -1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstValid", 32'(instr_valid), 32'h0);
        checkOutput("rstOutZero", Instr | PC | PCPlus4, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("rstErr", 32'(misalign_err), 32'h0);
`endif
        @(negedge clk);
        reset      = 1'b1;
        cyc        = 0;
        reqCount   = 0;
        popCount   = 0;
        memLatMin  = 1;
        memLatMax  = 1;
        halted     = 1'b0;
        expIssuePc = 32'h0;
        expOutPc   = 32'h0;
    endtask

    // One clock cycle: drive memory response and inputs, observe, update model, advance.
    task automatic applyStimulus(input logic ready, input logic reqReady,
                                 input logic redir, input logic [31:0] redirPc);
        int due;
        if (memDueQ.size() > 0 && memDueQ[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memData(memAddrQ[0]);
            void'(memAddrQ.pop_front());
            void'(memDueQ.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        instr_ready    = ready;
        imem_req_ready = reqReady;
        redirect_valid = redir;
        redirect_pc    = redirPc;
        #1;
        lastReqValid   = imem_req_valid;
        lastReqAddr    = imem_req_addr;
        lastInstrValid = instr_valid;
        lastPc         = PC;
        lastRspValid   = imem_rsp_valid;
        if (redir) checkOutput("noReqOnRedirect", 32'(imem_req_valid), 32'h0);
        if (halted) begin
            checkOutput("haltNoReq", 32'(imem_req_valid), 32'h0);
            checkOutput("haltNoOut", 32'(instr_valid), 32'h0);
        end
        if (imem_req_valid && imem_req_ready) begin
            checkOutput("reqAddr", imem_req_addr, expIssuePc);
            expIssuePc = expIssuePc + 32'd4;
            reqCount++;
            due = cyc + $urandom_range(memLatMin, memLatMax);
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memAddrQ.push_back(imem_req_addr);
            memDueQ.push_back(due);
        end
        if (instr_valid && instr_ready && !redir) begin
            checkOutput("outPc", PC, expOutPc);
            checkOutput("outInstr", Instr, memData(expOutPc));
            checkOutput("outPcPlus4", PCPlus4, expOutPc + 32'd4);
            expOutPc = expOutPc + 32'd4;
            popCount++;
        end else if (!instr_valid) begin
            checkOutput("emptyZero", Instr | PC | PCPlus4, 32'h0);
        end
        if (redir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirPc[1:0] != 2'b00) begin
                halted = 1'b1;
            end else begin
                expIssuePc = {redirPc[31:2], 2'b00};
                expOutPc   = {redirPc[31:2], 2'b00};
            end
`else
            expIssuePc = {redirPc[31:2], 2'b00};
            expOutPc   = {redirPc[31:2], 2'b00};
`endif
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] tgt;

        $display("[TB] sequential fetch, 1-cycle memory");
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            if (i == 0) begin
                checkOutput("t1ReqCycle0", 32'(lastReqValid), 32'h1);
                checkOutput("t1Addr0", lastReqAddr, 32'h0);
            end
            checkOutput("t1Valid", 32'(lastInstrValid), (i >= 2) ? 32'h1 : 32'h0);
        end
        checkOutput("t1PopCount", popCount, 32'd4);

        $display("[TB] decoder stall fills the queue");
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2ReqCount", reqCount, 32'd4);
        checkOutput("t2ReqBlocked", 32'(lastReqValid), 32'h0);
        checkOutput("t2Full", 32'(lastInstrValid), 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2Drain", popCount, 32'd4);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2Resume", popCount, 32'd10);

        $display("[TB] redirect with two requests in flight, 3-cycle memory");
        doReset();
        memLatMin = 3;
        memLatMax = 3;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("t3NoStale", 32'(lastInstrValid), 32'h0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3Valid", 32'(lastInstrValid), 32'h1);
        checkOutput("t3Pc", lastPc, 32'h100);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] redirect coinciding with response and pop");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        checkOutput("t4RspInRedirect", 32'(lastRspValid), 32'h1);
        checkOutput("t4PopOffered", 32'(lastInstrValid), 32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4EmptyAfter", 32'(lastInstrValid), 32'h0);
        checkOutput("t4ReqTarget", 32'(lastReqValid), 32'h1);
        checkOutput("t4Addr", lastReqAddr, 32'h200);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4Resumed", popCount, 32'd4);

        $display("[TB] PC wrap at top of address space");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5WrapReq", 32'(lastReqValid), 32'h1);
        checkOutput("t5WrapAddr", lastReqAddr, 32'h0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] misaligned redirect target");
        doReset();
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("t6Halt", 32'(lastReqValid), 32'h0);
            checkOutput("t6Err", 32'(misalign_err), 32'h1);
        end
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6ReqAfterReset", 32'(lastReqValid), 32'h1);
`else
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6Req", 32'(lastReqValid), 32'h1);
        checkOutput("t6Addr", lastReqAddr, 32'h100);
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`endif

        $display("[TB] randomized traffic against reference model");
        doReset();
        memLatMin = 1;
        memLatMax = 4;
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFE0 | (tgt & 32'h0000_001F);
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 19) == 0, tgt);
        end
        checkOutput("rndProgress", 32'(popCount > 500), 32'h1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
